// File: rtl/clock_divider_multi.sv
// ---------------------------------------------------------------------------
// clock_divider_multi
//   A bank of N_CH independent clock dividers running off one system clock.
//   Each channel produces a ~50% duty divided clock plus a one-cycle tick
//   strobe per divided period. Divisors are written at runtime through a
//   small write port and only take effect when the channel's period wraps
//   (or immediately while the channel is disabled), so the divided clock
//   never shows a runt pulse.
//
//   Optional feature macro: GLOBAL_SYNC_EN
//     When defined, an extra input sync_restart phase-aligns every channel
//     by holding all counters at zero and applying any pending divisor.
//     When undefined, the port does not exist and channels only realign
//     through reset or their enables.
// ---------------------------------------------------------------------------
module clock_divider_multi #(
   parameter int               N_CH        = 4,
   parameter int               CH_W        = 2,
   parameter int               CNT_W       = 28,
   parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(6666666)
) (
   input  logic              clock_in,
   input  logic              reset,
   input  logic [N_CH-1:0]   enable,
   input  logic              wr_en,
   input  logic [CH_W-1:0]   wr_ch,
   input  logic [CNT_W-1:0]  wr_div,
`ifdef GLOBAL_SYNC_EN
   input  logic              sync_restart,
`endif
   output logic              wr_ack,
   output logic [N_CH-1:0]   clk_out,
   output logic [N_CH-1:0]   tick
);

   // One extra bit so the channel-count limit fits even when N_CH == 2**CH_W.
   localparam logic [CH_W:0] NCH_LIM = (CH_W + 1)'(N_CH);

   logic              w_wrAccept;
   logic [CNT_W-1:0]  w_clampDiv;
   logic              w_sync;
   logic              r_wrAck;

   // A write is only honoured when it addresses a channel that exists.
   assign w_wrAccept = wr_en && ({1'b0, wr_ch} < NCH_LIM);

   // Divisors below 2 cannot produce a clock, so they are raised to 2.
   assign w_clampDiv = (wr_div < CNT_W'(2)) ? CNT_W'(2) : wr_div;

`ifdef GLOBAL_SYNC_EN
   assign w_sync = sync_restart;
`else
   assign w_sync = 1'b0;
`endif

   // Acknowledge pulse: registered one cycle after an accepted write.
   always_ff @(posedge clock_in) begin
      if (reset) begin
         r_wrAck <= 1'b0;
      end else begin
         r_wrAck <= w_wrAccept;
      end
   end

   assign wr_ack = r_wrAck;

   for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] r_divAct;
      logic [CNT_W-1:0] r_divPend;
      logic             r_pend;
      logic             r_clkOut;
      logic             r_tick;

      logic [CNT_W-1:0] w_cntNext;
      logic [CNT_W-1:0] w_divActNext;
      logic [CNT_W-1:0] w_divPendNext;
      logic             w_pendNext;
      logic             w_clkNext;
      logic             w_tickNext;
      logic [CNT_W-1:0] w_lastCnt;
      logic             w_wrap;
      logic             w_wrHit;

      // Last count of the period; anything at or beyond it wraps, which also
      // pulls a counter back into range after a divisor shrink.
      assign w_lastCnt = r_divAct - CNT_W'(1);
      assign w_wrap    = (r_cnt >= w_lastCnt);
      assign w_wrHit   = w_wrAccept && (wr_ch == CH_W'(gi));

      // Next-state logic for one channel. A stopped channel (disabled or
      // held by the global restart) sits at count zero with quiet outputs
      // and adopts a pending divisor straight away. A running channel
      // counts, derives its clock and tick from the current count, and
      // swaps in a pending divisor only at its wrap. A write landing this
      // cycle is recorded last, so it never takes effect at the wrap that
      // happens on the same edge.
      always_comb begin
         w_cntNext     = r_cnt;
         w_divActNext  = r_divAct;
         w_divPendNext = r_divPend;
         w_pendNext    = r_pend;
         w_clkNext     = 1'b0;
         w_tickNext    = 1'b0;

         if (w_sync || !enable[gi]) begin
            w_cntNext = '0;
            if (r_pend) begin
               w_divActNext = r_divPend;
               w_pendNext   = 1'b0;
            end
         end else begin
            w_clkNext  = (r_cnt < (r_divAct >> 1));
            w_tickNext = (r_cnt == w_lastCnt);
            if (w_wrap) begin
               w_cntNext = '0;
               if (r_pend) begin
                  w_divActNext = r_divPend;
                  w_pendNext   = 1'b0;
               end
            end else begin
               w_cntNext = r_cnt + CNT_W'(1);
            end
         end

         if (w_wrHit) begin
            w_divPendNext = w_clampDiv;
            w_pendNext    = 1'b1;
         end
      end

      // Channel state and registered outputs; reset discards pending writes.
      always_ff @(posedge clock_in) begin
         if (reset) begin
            r_cnt     <= '0;
            r_divAct  <= DEFAULT_DIV;
            r_divPend <= DEFAULT_DIV;
            r_pend    <= 1'b0;
            r_clkOut  <= 1'b0;
            r_tick    <= 1'b0;
         end else begin
            r_cnt     <= w_cntNext;
            r_divAct  <= w_divActNext;
            r_divPend <= w_divPendNext;
            r_pend    <= w_pendNext;
            r_clkOut  <= w_clkNext;
            r_tick    <= w_tickNext;
         end
      end

      assign clk_out[gi] = r_clkOut;
      assign tick[gi]    = r_tick;
   end

endmodule

// File: tb/tb_clock_divider_multi.sv
// ---------------------------------------------------------------------------
// tb_clock_divider_multi
//   Self-checking bench for clock_divider_multi with DEFAULT_DIV=10, N_CH=4
//   and a 3-bit channel select so out-of-range channels can be addressed.
//   Builds with or without GLOBAL_SYNC_EN.
// ---------------------------------------------------------------------------
module tb_clock_divider_multi;

   localparam int N_CH  = 4;
   localparam int CH_W  = 3;
   localparam int CNT_W = 28;

   logic              clock_in = 1'b0;
   logic              reset;
   logic [N_CH-1:0]   enable;
   logic              wr_en;
   logic [CH_W-1:0]   wr_ch;
   logic [CNT_W-1:0]  wr_div;
   logic              wr_ack;
   logic [N_CH-1:0]   clk_out;
   logic [N_CH-1:0]   tick;
`ifdef GLOBAL_SYNC_EN
   logic              sync_restart;
`endif

   int compared   = 0;
   int mismatched = 0;

   // Reference model: position inside the current period, active divisor
   // and an optional queued divisor per channel.
   int              mPos     [N_CH];
   int              mDiv     [N_CH];
   int              mPendDiv [N_CH];
   bit              mPend    [N_CH];
   logic [N_CH-1:0] mClk;
   logic [N_CH-1:0] mTick;
   logic            mAck;

   typedef struct {
      bit              rst;
      logic [N_CH-1:0] en;
      bit              we;
      int              ch;
      int              dv;
      logic [N_CH-1:0] eClk;
      logic [N_CH-1:0] eTick;
      bit              eAck;
   } vec_t;

   vec_t vecs [9];

   clock_divider_multi #(
      .N_CH        (N_CH),
      .CH_W        (CH_W),
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (28'd10)
   ) dut (
      .clock_in     (clock_in),
      .reset        (reset),
      .enable       (enable),
      .wr_en        (wr_en),
      .wr_ch        (wr_ch),
      .wr_div       (wr_div),
`ifdef GLOBAL_SYNC_EN
      .sync_restart (sync_restart),
`endif
      .wr_ack       (wr_ack),
      .clk_out      (clk_out),
      .tick         (tick)
   );

   // 10-unit system clock.
   always #5 clock_in = ~clock_in;

   // Advance the reference model by one system clock edge.
   function automatic void modelStep(bit rst, logic [N_CH-1:0] en, bit we, int ch, int dv, bit sy);
      if (rst) begin
         for (int c = 0; c < N_CH; c++) begin
            mPos[c] = 0; mDiv[c] = 10; mPendDiv[c] = 10; mPend[c] = 0;
         end
         mClk = '0; mTick = '0; mAck = 1'b0;
         return;
      end
      for (int c = 0; c < N_CH; c++) begin
         mClk[c]  = 1'b0;
         mTick[c] = 1'b0;
         if (sy || !en[c]) begin
            mPos[c] = 0;
            if (mPend[c]) begin mDiv[c] = mPendDiv[c]; mPend[c] = 0; end
         end else begin
            mClk[c]  = (mPos[c] < mDiv[c] / 2);
            mTick[c] = (mPos[c] == mDiv[c] - 1);
            if (mPos[c] >= mDiv[c] - 1) begin
               mPos[c] = 0;
               if (mPend[c]) begin mDiv[c] = mPendDiv[c]; mPend[c] = 0; end
            end else begin
               mPos[c] = mPos[c] + 1;
            end
         end
         if (we && ch == c) begin
            mPendDiv[c] = (dv < 2) ? 2 : dv;
            mPend[c]    = 1;
         end
      end
      mAck = we && (ch < N_CH);
   endfunction

   // Drive one cycle of inputs, let the edge happen, update the model.
   task automatic applyStimulus(bit rst, logic [N_CH-1:0] en, bit we, int ch, int dv, bit sy);
      reset  = rst;
      enable = en;
      wr_en  = we;
      wr_ch  = CH_W'(ch);
      wr_div = CNT_W'(dv);
`ifdef GLOBAL_SYNC_EN
      sync_restart = sy;
`endif
      @(posedge clock_in);
      modelStep(rst, en, we, ch, dv, sy);
      #1;
   endtask

   // Single comparison with failure report.
   task automatic checkOne(string name, logic [31:0] act, logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare all DUT outputs against a set of expected values.
   task automatic checkOutput(string name, logic [N_CH-1:0] eClk, logic [N_CH-1:0] eTick, logic eAck);
      checkOne({name, ".clk_out"}, 32'(clk_out), 32'(eClk));
      checkOne({name, ".tick"},    32'(tick),    32'(eTick));
      checkOne({name, ".wr_ack"},  32'(wr_ack),  32'(eAck));
   endtask

   initial begin
      int firstTick;
      int highCnt;
      int lowCnt;
      int t1a, t1b, t0a, t0b;
      int tog2, tog3;
      logic prev2, prev3;

      reset = 1'b1; enable = '0; wr_en = 1'b0; wr_ch = '0; wr_div = '0;
`ifdef GLOBAL_SYNC_EN
      sync_restart = 1'b0;
`endif

      // Hand-derived vectors: reset, ignored/clamped writes while disabled,
      // then ch0 (div 2) and ch1 (div 10) running side by side.
      vecs[0] = '{1'b1, 4'h0, 1'b0, 0, 0, 4'h0, 4'h0, 1'b0};
      vecs[1] = '{1'b0, 4'h0, 1'b1, 5, 3, 4'h0, 4'h0, 1'b0};
      vecs[2] = '{1'b0, 4'h0, 1'b1, 0, 0, 4'h0, 4'h0, 1'b1};
      vecs[3] = '{1'b0, 4'h0, 1'b0, 0, 0, 4'h0, 4'h0, 1'b0};
      vecs[4] = '{1'b0, 4'h3, 1'b0, 0, 0, 4'h3, 4'h0, 1'b0};
      vecs[5] = '{1'b0, 4'h3, 1'b0, 0, 0, 4'h2, 4'h1, 1'b0};
      vecs[6] = '{1'b0, 4'h3, 1'b0, 0, 0, 4'h3, 4'h0, 1'b0};
      vecs[7] = '{1'b0, 4'h3, 1'b1, 7, 9, 4'h2, 4'h1, 1'b0};
      vecs[8] = '{1'b1, 4'h3, 1'b0, 0, 0, 4'h0, 4'h0, 1'b0};

      for (int v = 0; v < 9; v++) begin
         applyStimulus(vecs[v].rst, vecs[v].en, vecs[v].we, vecs[v].ch, vecs[v].dv, 1'b0);
         checkOutput($sformatf("vec%0d", v), vecs[v].eClk, vecs[v].eTick, vecs[v].eAck);
      end

      // Release from reset, all channels on: 5 high / 5 low, first tick at 10.
      applyStimulus(1'b1, 4'h0, 1'b0, 0, 0, 1'b0);
      checkOutput("s1Reset", mClk, mTick, mAck);
      firstTick = -1; highCnt = 0;
      for (int k = 1; k <= 20; k++) begin
         applyStimulus(1'b0, 4'hF, 1'b0, 0, 0, 1'b0);
         checkOutput("s1Run", mClk, mTick, mAck);
         if (clk_out[0]) highCnt++;
         if (tick[0] && firstTick < 0) firstTick = k;
      end
      checkOne("s1FirstTick", 32'(firstTick), 32'd10);
      checkOne("s1HighCycles", 32'(highCnt), 32'd10);

      // Mid-period write of 7 to ch1; ch0 must keep its period.
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 4'hF, 1'b0, 0, 0, 1'b0);
         checkOutput("s2Pre", mClk, mTick, mAck);
      end
      applyStimulus(1'b0, 4'hF, 1'b1, 1, 7, 1'b0);
      checkOne("s2Ack", 32'(wr_ack), 32'd1);
      t1a = 0; t1b = 0; t0a = 0; t0b = 0;
      for (int k = 1; k <= 40; k++) begin
         applyStimulus(1'b0, 4'hF, 1'b0, 0, 0, 1'b0);
         checkOutput("s2Run", mClk, mTick, mAck);
         if (tick[1]) begin t1a = t1b; t1b = k; end
         if (tick[0]) begin t0a = t0b; t0b = k; end
      end
      checkOne("s2Ch1Period", 32'(t1b - t1a), 32'd7);
      checkOne("s2Ch0Period", 32'(t0b - t0a), 32'd10);

      // Divisors 0 and 1 clamp to 2: toggle every cycle.
      applyStimulus(1'b0, 4'hF, 1'b1, 2, 0, 1'b0);
      checkOutput("s3Wr0", mClk, mTick, mAck);
      applyStimulus(1'b0, 4'hF, 1'b1, 3, 1, 1'b0);
      checkOutput("s3Wr1", mClk, mTick, mAck);
      tog2 = 0; tog3 = 0; prev2 = clk_out[2]; prev3 = clk_out[3];
      for (int k = 1; k <= 30; k++) begin
         applyStimulus(1'b0, 4'hF, 1'b0, 0, 0, 1'b0);
         checkOutput("s3Run", mClk, mTick, mAck);
         if (k > 20) begin
            if (clk_out[2] != prev2) tog2++;
            if (clk_out[3] != prev3) tog3++;
         end
         prev2 = clk_out[2]; prev3 = clk_out[3];
      end
      checkOne("s3Ch2Toggles", 32'(tog2), 32'd10);
      checkOne("s3Ch3Toggles", 32'(tog3), 32'd10);

      // Write to a non-existent channel is ignored.
      applyStimulus(1'b0, 4'hF, 1'b1, 5, 3, 1'b0);
      checkOne("s4NoAck", 32'(wr_ack), 32'd0);
      for (int k = 0; k < 20; k++) begin
         applyStimulus(1'b0, 4'hF, 1'b0, 0, 0, 1'b0);
         checkOutput("s4Run", mClk, mTick, mAck);
      end

      // Drop enable[2] for 3 cycles (restoring div 10), then re-enable.
      lowCnt = 0;
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 4'hB, (k == 0), 2, 10, 1'b0);
         checkOutput("s5Off", mClk, mTick, mAck);
         if (!clk_out[2]) lowCnt++;
      end
      checkOne("s5LowWhileOff", 32'(lowCnt), 32'd3);
      firstTick = -1;
      for (int k = 1; k <= 12; k++) begin
         applyStimulus(1'b0, 4'hF, 1'b0, 0, 0, 1'b0);
         checkOutput("s5On", mClk, mTick, mAck);
         if (k == 1) checkOne("s5FirstHigh", 32'(clk_out[2]), 32'd1);
         if (tick[2] && firstTick < 0) firstTick = k;
      end
      checkOne("s5TickAfterEnable", 32'(firstTick), 32'd10);

`ifdef GLOBAL_SYNC_EN
      // Misalign ch0 (div 10) and ch3 (div 4), then restart them together.
      applyStimulus(1'b0, 4'hF, 1'b1, 3, 4, 1'b0);
      checkOutput("s6Wr", mClk, mTick, mAck);
      for (int k = 0; k < 7; k++) begin
         applyStimulus(1'b0, 4'hF, 1'b0, 0, 0, 1'b0);
         checkOutput("s6Pre", mClk, mTick, mAck);
      end
      applyStimulus(1'b0, 4'hF, 1'b0, 0, 0, 1'b1);
      checkOutput("s6Sync", mClk, mTick, mAck);
      highCnt = 0;
      for (int k = 1; k <= 40; k++) begin
         applyStimulus(1'b0, 4'hF, 1'b0, 0, 0, 1'b0);
         checkOutput("s6Run", mClk, mTick, mAck);
         if (k == 1) checkOne("s6Aligned", 32'({clk_out[0], clk_out[3]}), 32'd3);
         if (tick[0] && tick[3]) highCnt++;
      end
      checkOne("s6CoincidentTicks", 32'(highCnt), 32'd2);
`endif

      // Randomised traffic against the reference model.
      for (int k = 0; k < 600; k++) begin
         bit              rr;
         logic [N_CH-1:0] ee;
         bit              ww;
         bit              ss;
         rr = ($urandom_range(0, 99) == 0);
         ee = ($urandom_range(0, 3) == 0) ? N_CH'($urandom) : '1;
         ww = ($urandom_range(0, 5) == 0);
         ss = 1'b0;
`ifdef GLOBAL_SYNC_EN
         ss = ($urandom_range(0, 49) == 0);
`endif
         applyStimulus(rr, ee, ww, $urandom_range(0, 7), $urandom_range(0, 12), ss);
         checkOutput("rand", mClk, mTick, mAck);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
